// File: rtl/axi_pkg.sv
// Shared AXI definitions: response encodings, burst-length width and the
// FSM state types used by the default slave.
package axi_pkg;

    localparam int AXI_LEN_W = 8;

    localparam logic [AXI_LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [AXI_LEN_W-1:0] LEN_ONE  = AXI_LEN_W'(1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_default_slave_rd.sv
// Read half of the default slave: accepts one AR burst at a time and
// returns arlen+1 DECERR beats carrying the fill pattern.
module axi_default_slave_rd
    import axi_pkg::*;
#(
    parameter int          IDW        = 4,
    parameter int          DW         = 32,
    parameter logic [31:0] RDATA_FILL = 32'h0
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic [IDW-1:0]       arid,
    input  logic [AXI_LEN_W-1:0] arlen,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [IDW-1:0]       rid,
    output logic [DW-1:0]        rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready
);

    localparam logic [DW-1:0] FILL_DW = DW'(RDATA_FILL);

    rd_state_t            state;
    logic [AXI_LEN_W-1:0] cnt;

    // Read FSM: cnt holds beats remaining after the one on the bus, so rlast
    // is precomputed and registered alongside the beat it qualifies.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state   <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            cnt     <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rid     <= arid;
                        cnt     <= arlen;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == LEN_ZERO);
                        rresp   <= RESP_DECERR;
                        rdata   <= FILL_DW;
                        state   <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            state   <= R_IDLE;
                        end else begin
                            cnt   <= cnt - 1'b1;
                            rlast <= (cnt == LEN_ONE);
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave: terminates every unmapped write and read burst with
// DECERR while honouring the full handshake. Write and read paths run
// independently, one outstanding burst per direction.
// Optional macro AXI_DEFAULT_SLAVE_WLEN_CHECK_EN: write bursts end on the
// awlen+1 count instead of WLAST, and WLAST disagreement sets a sticky
// o_proto_err.
module axi_default_slave
    import axi_pkg::*;
#(
    parameter int          IDW        = 4,
    parameter int          AW         = 32,
    parameter int          DW         = 32,
    parameter logic [31:0] RDATA_FILL = 32'h0
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic [IDW-1:0]       s_awid,
    input  logic [AW-1:0]        s_awaddr,
    input  logic [AXI_LEN_W-1:0] s_awlen,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [DW-1:0]        s_wdata,
    input  logic [DW/8-1:0]      s_wstrb,
    input  logic                 s_wlast,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [IDW-1:0]       s_bid,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    input  logic [IDW-1:0]       s_arid,
    input  logic [AW-1:0]        s_araddr,
    input  logic [AXI_LEN_W-1:0] s_arlen,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [IDW-1:0]       s_rid,
    output logic [DW-1:0]        s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rlast,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic                 o_proto_err
);

    wr_state_t      wstate;
    logic [IDW-1:0] awid_q;
    logic           w_term;
    logic           unused_ok;

`ifdef AXI_DEFAULT_SLAVE_WLEN_CHECK_EN
    logic [AXI_LEN_W-1:0] awlen_q;
    logic [AXI_LEN_W-1:0] wcnt;
    logic                 proto_err;

    // The burst length is authoritative; WLAST is only cross-checked.
    assign w_term      = (wcnt == awlen_q);
    assign o_proto_err = proto_err;
    assign unused_ok   = ^{s_awaddr, s_araddr, s_wdata, s_wstrb};

    // Beat counter and sticky WLAST-vs-count mismatch flag.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            awlen_q   <= '0;
            wcnt      <= '0;
            proto_err <= 1'b0;
        end else begin
            if (wstate == W_IDLE && s_awvalid && s_awready) begin
                awlen_q <= s_awlen;
                wcnt    <= '0;
            end
            if (s_wvalid && s_wready) begin
                wcnt <= wcnt + 1'b1;
                if (s_wlast != w_term)
                    proto_err <= 1'b1;
            end
        end
    end
`else
    assign w_term      = s_wlast;
    assign o_proto_err = 1'b0;
    assign unused_ok   = ^{s_awaddr, s_araddr, s_wdata, s_wstrb, s_awlen};
`endif

    // Write FSM: accept AW, sink W beats until the terminating beat, then
    // hold a DECERR B response until it is taken.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wstate    <= W_IDLE;
            awid_q    <= '0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (s_awvalid && s_awready) begin
                        awid_q    <= s_awid;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b1;
                        wstate    <= W_DATA;
                    end else begin
                        s_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_wvalid && s_wready && w_term) begin
                        s_wready <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bid    <= awid_q;
                        s_bresp  <= RESP_DECERR;
                        wstate   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_bvalid && s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        wstate    <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    axi_default_slave_rd #(
        .IDW        (IDW),
        .DW         (DW),
        .RDATA_FILL (RDATA_FILL)
    ) u_rd (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .arid     (s_arid),
        .arlen    (s_arlen),
        .arvalid  (s_arvalid),
        .arready  (s_arready),
        .rid      (s_rid),
        .rdata    (s_rdata),
        .rresp    (s_rresp),
        .rlast    (s_rlast),
        .rvalid   (s_rvalid),
        .rready   (s_rready)
    );

endmodule
